// File: rtl/serial_byte_rx.sv
// Framed 1-bit LSB-first byte receiver feeding a small valid/ready FIFO.
// Define SERIAL_RX_PARITY_EN to add an even-parity bit between data and stop.
module serial_byte_rx #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_in,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic [AW:0]   fifo_level,
    output logic          frame_err,
    output logic          overflow
);

    // state  | meaning
    // IDLE   | line idle, waiting for a high start bit
    // DATA   | shifting in 8 data bits, LSB first
    // PAR    | sampling the even-parity bit (parity builds only)
    // STOP   | sampling the stop bit; push or flag the byte
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
`ifdef SERIAL_RX_PARITY_EN
    localparam logic [1:0] S_PAR  = 2'd2;
`endif
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        frame_err_q, frame_err_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  mem_q [DEPTH];

    logic        stop_ok;
    logic        byte_good;
    logic        byte_bad;
    logic        full;
    logic        pop;
    logic        push;

`ifdef SERIAL_RX_PARITY_EN
    logic        par_bad_q, par_bad_d;
    assign stop_ok = !serial_in && !par_bad_q;
`else
    assign stop_ok = !serial_in;
`endif

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
`ifdef SERIAL_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (serial_in) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            S_DATA: begin
                shreg_d   = {serial_in, shreg_q[7:1]};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_STOP;
`endif
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            S_PAR: begin
                par_bad_d = ^{shreg_q, serial_in};
                state_d   = S_STOP;
            end
`endif
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign byte_good = (state_q == S_STOP) && stop_ok;
    assign byte_bad  = (state_q == S_STOP) && !stop_ok;

    assign full = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop  = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot the push is about to use.
    assign push = byte_good && (!full || pop);

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        frame_err_d = byte_bad;
        overflow_d  = byte_good && full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
`ifdef SERIAL_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shreg_q;
        end
    end

    assign rx_valid   = (wr_ptr_q != rd_ptr_q);
    assign rx_data    = rx_valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'd0;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx: framing, FIFO ordering, overflow, errors, reset.
module tb_serial_byte_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial_in = 1'b0;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_level;
    logic       frame_err;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    serial_byte_rx #(.DEPTH(4), .AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit for one cycle; returns 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        serial_in = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Start, 8 data bits LSB first, [even parity], stop; rx_ready driven rdy from the stop bit on.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic rdy);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        send_bit(^d);
`endif
        rx_ready = rdy;
        send_bit(stop_b);
        serial_in = 1'b0;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        idle(3);
        check("idle_level", fifo_level, 0);

        // single frame A5, consumer ready
        send_frame(8'hA5, 1'b0, 1'b1);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_level", fifo_level, 1);
        idle(1);
        check("a5_popped_valid", rx_valid, 0);
        check("a5_popped_level", fifo_level, 0);

        // back-to-back frames, consumer stalled
        send_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0);
        check("b2b_level", fifo_level, 3);
        check("b2b_head0", rx_data, 8'h01);
        rx_ready = 1'b1;
        idle(1);
        check("b2b_head1", rx_data, 8'hFF);
        check("b2b_level2", fifo_level, 2);
        idle(1);
        check("b2b_head2", rx_data, 8'h80);
        idle(1);
        check("b2b_empty", rx_valid, 0);
        check("b2b_level0", fifo_level, 0);
        rx_ready = 1'b0;

        // overflow on the fifth frame
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0);
        check("ovf_full_level", fifo_level, 4);
        check("ovf_none_yet", overflow, 0);
        send_frame(8'h55, 1'b0, 1'b0);
        check("ovf_pulse", overflow, 1);
        check("ovf_level", fifo_level, 4);
        check("ovf_head", rx_data, 8'h11);
        idle(1);
        check("ovf_pulse_end", overflow, 0);
        rx_ready = 1'b1;
        idle(1);
        check("ovf_d1", rx_data, 8'h22);
        idle(1);
        check("ovf_d2", rx_data, 8'h33);
        idle(1);
        check("ovf_d3", rx_data, 8'h44);
        idle(1);
        check("ovf_drained", fifo_level, 0);
        rx_ready = 1'b0;

        // full FIFO with a pop on the fifth frame's stop cycle
        send_frame(8'hA1, 1'b0, 1'b0);
        send_frame(8'hA2, 1'b0, 1'b0);
        send_frame(8'hA3, 1'b0, 1'b0);
        send_frame(8'hA4, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b1);
        check("fp_no_ovf", overflow, 0);
        check("fp_level", fifo_level, 4);
        check("fp_d2", rx_data, 8'hA2);
        idle(1);
        check("fp_d3", rx_data, 8'hA3);
        idle(1);
        check("fp_d4", rx_data, 8'hA4);
        idle(1);
        check("fp_d5", rx_data, 8'hA5);
        check("fp_level1", fifo_level, 1);
        idle(1);
        check("fp_empty", rx_valid, 0);
        rx_ready = 1'b0;

        // framing error then good frame
        send_frame(8'h3C, 1'b1, 1'b0);
        check("ferr_pulse", frame_err, 1);
        check("ferr_level", fifo_level, 0);
        idle(1);
        check("ferr_pulse_end", frame_err, 0);
        check("ferr_no_start", rx_valid, 0);
        send_frame(8'h3C, 1'b0, 1'b0);
        check("ferr_good_valid", rx_valid, 1);
        check("ferr_good_data", rx_data, 8'h3C);
        check("ferr_good_noerr", frame_err, 0);
        rx_ready = 1'b1;
        idle(1);
        check("ferr_drained", fifo_level, 0);
        rx_ready = 1'b0;

        // reset in the middle of a frame, with a byte already queued
        send_frame(8'h5A, 1'b0, 1'b0);
        check("mr_pre_level", fifo_level, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        #1;
        check("mr_valid", rx_valid, 0);
        check("mr_data", rx_data, 0);
        check("mr_level", fifo_level, 0);
        serial_in = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(12);
        check("mr_no_partial", fifo_level, 0);
        send_frame(8'hC3, 1'b0, 1'b0);
        check("mr_next_valid", rx_valid, 1);
        check("mr_next_data", rx_data, 8'hC3);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;

`ifdef SERIAL_RX_PARITY_EN
        // 8'h07 needs parity bit 1; send 0 first
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(i < 3);
        send_bit(1'b0);
        send_bit(1'b0);
        serial_in = 1'b0;
        check("par_bad_ferr", frame_err, 1);
        check("par_bad_level", fifo_level, 0);
        idle(1);
        send_frame(8'h07, 1'b0, 1'b0);
        check("par_ok_ferr", frame_err, 0);
        check("par_ok_data", rx_data, 8'h07);
        check("par_ok_level", fifo_level, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
